// File: rtl/sdr_tune_ctrl_if.sv
// Byte-in / tuning-state-out bundle between the UART receiver side and sdr_tune_ctrl.
// master drives received bytes; slave (the controller) drives tuning state and strobes.
interface sdr_tune_ctrl_if #(
    parameter int unsigned PHASE_WIDTH = 64,
    parameter int unsigned GAIN_WIDTH  = 2
);
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic [PHASE_WIDTH-1:0] phase_increment;
    logic [GAIN_WIDTH-1:0]  gain;
    logic                   update;
    logic                   busy;
    logic                   cmd_error;

    modport master (
        output rx_valid, rx_byte,
        input  phase_increment, gain, update, busy, cmd_error
    );

    modport slave (
        input  rx_valid, rx_byte,
        output phase_increment, gain, update, busy, cmd_error
    );
endinterface

// File: rtl/sdr_tune_ctrl.sv
// UART command decoder owning the NCO phase increment and CIC gain select.
// Single-key presets/steps in IDLE; MSB-first hex direct entry with abort and timeout in HEX.
module sdr_tune_ctrl #(
    parameter int unsigned PHASE_WIDTH    = 64,
    parameter int unsigned GAIN_WIDTH     = 2,
    parameter logic [PHASE_WIDTH-1:0] PRESET_A    = 64'h3dafcea68de1281,
    parameter logic [PHASE_WIDTH-1:0] PRESET_B    = 64'h1aa60f8b8911654,
    parameter logic [PHASE_WIDTH-1:0] PRESET_F    = 64'h1dc38c076704516d,
    parameter logic [PHASE_WIDTH-1:0] PRESET_G    = 64'h1d60d923295482c6,
    parameter logic [PHASE_WIDTH-1:0] STEP_COARSE = 64'h71b375868d170,
    parameter logic [PHASE_WIDTH-1:0] STEP_MEDIUM = 64'hca22980ba57e,
    parameter logic [PHASE_WIDTH-1:0] STEP_FINE   = 64'h1436a8cdf6f3,
    parameter int unsigned TIMEOUT_CYCLES = 80_000_000
) (
    input  logic             clk,
    input  logic             arst,
    sdr_tune_ctrl_if.slave   bus
);

    localparam int unsigned DIGITS  = PHASE_WIDTH / 4;
    localparam int unsigned CNT_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]  GAIN_LIM = 8'(2 ** GAIN_WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HEX  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [PHASE_WIDTH-1:0] r_phase;
    logic [GAIN_WIDTH-1:0]  r_gain;
    logic                   r_update;
    logic                   r_busy;
    logic                   r_cmd_error;
    logic [PHASE_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]       r_dig_cnt;
    logic [TO_W-1:0]        r_to_cnt;

    logic                   w_hex_ok;
    logic [3:0]             w_nib;
    logic                   w_is_dec;
    logic [7:0]             w_dec;
    logic                   w_gain_ok;
    logic                   w_step_up;
    logic                   w_step_dn;
    logic [PHASE_WIDTH-1:0] w_step;
    logic [PHASE_WIDTH:0]   w_sum;
    logic [PHASE_WIDTH-1:0] w_sat_add;
    logic [PHASE_WIDTH-1:0] w_sat_sub;
    logic [PHASE_WIDTH-1:0] w_shift_next;
    logic                   w_last_digit;
    logic                   w_timeout;

    // Hex digit decode, both letter cases
    always_comb begin
        w_hex_ok = 1'b0;
        w_nib    = 4'h0;
        if (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) begin
            w_hex_ok = 1'b1;
            w_nib    = 4'(bus.rx_byte - 8'h30);
        end else if (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h66) begin
            w_hex_ok = 1'b1;
            w_nib    = 4'(bus.rx_byte - 8'h57);
        end else if (bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h46) begin
            w_hex_ok = 1'b1;
            w_nib    = 4'(bus.rx_byte - 8'h37);
        end
    end

    // Decimal digits select gain only when the value fits GAIN_WIDTH
    always_comb begin
        w_is_dec  = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
        w_dec     = bus.rx_byte - 8'h30;
        w_gain_ok = w_is_dec && (w_dec < GAIN_LIM);
    end

    // Step key decode
    always_comb begin
        w_step    = '0;
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        case (bus.rx_byte)
            8'h6D: begin w_step = STEP_COARSE; w_step_up = 1'b1; end
            8'h6E: begin w_step = STEP_COARSE; w_step_dn = 1'b1; end
            8'h72: begin w_step = STEP_MEDIUM; w_step_up = 1'b1; end
            8'h71: begin w_step = STEP_MEDIUM; w_step_dn = 1'b1; end
            8'h70: begin w_step = STEP_FINE;   w_step_up = 1'b1; end
            8'h6F: begin w_step = STEP_FINE;   w_step_dn = 1'b1; end
            default: ;
        endcase
    end

    // Saturating arithmetic: carry out of the extra bit clamps to all-ones, borrow clamps to zero
    always_comb begin
        w_sum     = {1'b0, r_phase} + {1'b0, w_step};
        w_sat_add = w_sum[PHASE_WIDTH] ? '1 : w_sum[PHASE_WIDTH-1:0];
        w_sat_sub = (r_phase < w_step) ? '0 : (r_phase - w_step);
    end

    always_comb begin
        w_shift_next = (r_shift << 4) | PHASE_WIDTH'(w_nib);
        w_last_digit = (r_dig_cnt == CNT_W'(DIGITS - 1));
        w_timeout    = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_gain      <= '0;
            r_update    <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_error <= 1'b0;
            r_shift     <= '0;
            r_dig_cnt   <= '0;
            r_to_cnt    <= '0;
        end else begin
            r_update    <= 1'b0;
            r_cmd_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        if (w_is_dec) begin
                            if (w_gain_ok) begin
                                r_gain   <= GAIN_WIDTH'(w_dec);
                                r_update <= 1'b1;
                            end else begin
                                r_cmd_error <= 1'b1;
                            end
                        end else if (w_step_up) begin
                            r_phase  <= w_sat_add;
                            r_update <= 1'b1;
                        end else if (w_step_dn) begin
                            r_phase  <= w_sat_sub;
                            r_update <= 1'b1;
                        end else begin
                            case (bus.rx_byte)
                                8'h61: begin r_phase <= PRESET_A; r_update <= 1'b1; end
                                8'h62: begin r_phase <= PRESET_B; r_update <= 1'b1; end
                                8'h66: begin r_phase <= PRESET_F; r_update <= 1'b1; end
                                8'h67: begin r_phase <= PRESET_G; r_update <= 1'b1; end
                                8'h7A: begin r_phase <= '0;       r_update <= 1'b1; end
                                8'h78: begin
                                    r_state   <= ST_HEX;
                                    r_busy    <= 1'b1;
                                    r_shift   <= '0;
                                    r_dig_cnt <= '0;
                                    r_to_cnt  <= '0;
                                end
                                default: r_cmd_error <= 1'b1;
                            endcase
                        end
                    end
                end

                ST_HEX: begin
                    if (bus.rx_valid) begin
                        r_to_cnt <= '0;
                        if (w_hex_ok) begin
                            if (w_last_digit) begin
                                r_phase  <= w_shift_next;
                                r_update <= 1'b1;
                                r_state  <= ST_IDLE;
                                r_busy   <= 1'b0;
                            end else begin
                                r_shift   <= w_shift_next;
                                r_dig_cnt <= r_dig_cnt + CNT_W'(1);
                            end
                        end else begin
                            // ESC aborts quietly; anything else aborts with an error
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                            r_cmd_error <= (bus.rx_byte != 8'h1B);
                        end
                    end else if (w_timeout) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cmd_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase_increment = r_phase;
    assign bus.gain            = r_gain;
    assign bus.update          = r_update;
    assign bus.busy            = r_busy;
    assign bus.cmd_error       = r_cmd_error;

endmodule

// File: doc/sdr_tune_ctrl.md
# sdr_tune_ctrl

Parametrised UART command decoder that owns the receiver's tuning state: NCO phase increment and CIC gain select. It sits between `uart_rx` and the NCO/CIC instances in the SDR top level and is clocked by the 80 MHz system clock. Beyond single-key preset and step commands, it adds:
- saturating step arithmetic,
- a multi-byte hex direct-entry mode with abort and timeout,
- an error strobe,
- strict "unknown byte changes nothing" semantics.

## Interface
Parameters:
- PHASE_WIDTH, 64, width of phase increment; multiple of 4.
- GAIN_WIDTH, 2, width of gain select; 1..3.
- PRESET_A, 64'h3dafcea68de1281, loaded by 'a'.
- PRESET_B, 64'h1aa60f8b8911654, loaded by 'b'.
- PRESET_F, 64'h1dc38c076704516d, loaded by 'f'.
- PRESET_G, 64'h1d60d923295482c6, loaded by 'g'.
- STEP_COARSE, 64'h71b375868d170, 'm' adds, 'n' subtracts.
- STEP_MEDIUM, 64'hca22980ba57e, 'r' adds, 'q' subtracts.
- STEP_FINE, 64'h1436a8cdf6f3, 'p' adds, 'o' subtracts.
- TIMEOUT_CYCLES, 80_000_000, idle cycles before hex entry aborts.

Ports:
- clk  in  1  system clock.
- arst  in  1  reset. One clock; reset is asynchronous and active-high.
- rx_valid  in  1  one-cycle strobe, rx_byte valid.
- rx_byte  in  8  received ASCII byte.
- phase_increment  out  PHASE_WIDTH  NCO tuning word, unsigned, registered.
- gain  out  GAIN_WIDTH  CIC gain select, registered.
- update  out  1  one-cycle pulse: phase_increment or gain was written.
- busy  out  1  high while in HEX state.
- cmd_error  out  1  one-cycle pulse on a rejected byte or a timeout.

## Operation
- Reset values: phase_increment=0, gain=0, update=0, busy=0, cmd_error=0, state=IDLE, hex shift register=0, digit counter=0, timeout counter=0.
- States: IDLE and HEX. Bytes are acted on only in a cycle where rx_valid=1.
- IDLE command set:
  - ASCII '0'+d, for d < 2^GAIN_WIDTH: gain←d.
  - Digit '0'..'9' with d ≥ 2^GAIN_WIDTH: cmd_error; no change.
  - 'a', 'b', 'f', 'g': phase_increment←the corresponding PRESET.
  - 'm', 'r', 'p': phase_increment←min(phase_increment+STEP, 2^PHASE_WIDTH−1). Computed in PHASE_WIDTH+1 bits.
  - 'n', 'q', 'o': phase_increment←max(phase_increment−STEP, 0). Never wraps.
  - 'z': phase_increment←0.
  - 'x': enter HEX. Clear shift register, digit counter and timeout counter. No update pulse.
  - Any other byte: cmd_error; phase_increment and gain are unchanged.
- HEX state:
  - Accepts '0'-'9', 'a'-'f', 'A'-'F'. Each digit shifts in 4 bits at the LSB, so entry is MSB first.
  - After the PHASE_WIDTH/4-th digit: phase_increment←shift value, update pulse, return to IDLE.
  - ESC (8'h1B): return to IDLE, no change, no error.
  - Any other byte: return to IDLE, no change, cmd_error.
  - Timeout counter resets on every rx_valid. Reaching TIMEOUT_CYCLES → return to IDLE, cmd_error, no change.
  - Normal commands are not interpreted while in HEX.
- update pulses for every accepted write, including saturated or no-change writes (e.g. 'z' when already 0).
- gain is never altered by phase commands, and the reverse.
- update and cmd_error are never high in the same cycle.

## Timing
- Latency: rx_valid sampled at edge N → new phase_increment/gain and update (or cmd_error) visible after edge N, for exactly one cycle in the case of the pulses.
- busy rises after the edge that samples 'x' and falls after the edge that completes, aborts or times out the entry.
- Back-to-back rx_valid on consecutive cycles must be handled with no byte lost. Each step sees the result of the previous one.
- Timeout fires on the edge where the counter equals TIMEOUT_CYCLES−1 with rx_valid=0. If rx_valid=1 on that same edge, the byte wins and no timeout occurs.
- Reset mid-entry: all state returns to reset values immediately (asynchronously), and the partial value is discarded.
- Reset mid-pulse: update/cmd_error drop immediately.

## Test plan
- Reset, then 'a' → phase_increment=64'h3dafcea68de1281 one cycle after the strobe, update=1 for 1 cycle, gain=0.
- '2' then '7' (GAIN_WIDTH=2) → gain=2 with update; then cmd_error pulse, gain stays 2.
- 'z' then 'o' → phase_increment stays 0 (saturated), update pulses. Load 64'hFFFFFFFFFFFFFFF0 via hex, then 'm' → 64'hFFFFFFFFFFFFFFFF.
- 'x' + "0400000000000000" on back-to-back cycles → phase_increment=64'h0400000000000000 after the 16th digit, busy high throughout.
- 'x' "12" then 'k' → cmd_error, busy=0, phase unchanged. 'x' "12" then ESC → no error, unchanged. 'x' "12" then silence (TIMEOUT_CYCLES=100) → cmd_error exactly 100 cycles after the last byte.
- 'b' then unknown byte 8'h7E → phase stays 64'h1aa60f8b8911654, cmd_error pulse. arst asserted mid hex entry → all outputs 0 and state IDLE; a following 'p' adds STEP_FINE to 0.
